// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract engine, DIGIT bits per cycle
// Operands and result move over valid/ready handshakes; one full-adder slice with a registered carry.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic [DIGIT:0]   dig;
  logic [WIDTH-1:0] psum_next;
  logic [WIDTH-1:0] b_in;

  assign dig  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign b_in = sub ? ~b : b;

  // New digits enter at the MSB end so the sum is aligned after N shifts.
  if (DIGIT == WIDTH) begin : g_psum_full
    assign psum_next = dig[DIGIT-1:0];
  end else begin : g_psum_shift
    assign psum_next = {dig[DIGIT-1:0], psum_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    psum_d      = psum_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (ena && in_valid) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b_in;
          carry_d = sub;
          cnt_d   = '0;
          psum_d  = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b_in[WIDTH-1];
        end
      end
      S_RUN: begin
        if (ena) begin
          a_d     = a_q >> DIGIT;
          b_d     = b_q >> DIGIT;
          carry_d = dig[DIGIT];
          psum_d  = psum_next;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d     = S_DONE;
            cnt_d       = '0;
            sum_d       = psum_next;
            carry_out_d = dig[DIGIT];
            overflow_d  = (a_msb_q == b_msb_q) && (psum_next[WIDTH-1] != a_msb_q);
          end
        end
      end
      S_DONE: begin
        if (ena && out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      psum_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      psum_q      <= psum_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (8/1 and 16/4 instances)
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ena;

  logic       in_valid8, in_ready8, sub8, out_valid8, out_ready8, c8, ov8, busy8;
  logic [7:0] a8, b8, sum8;

  logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16, c16, ov16, busy16;
  logic [15:0] a16, b16, sum16;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
    .carry_out(c8), .overflow(ov8), .busy(busy8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16),
    .carry_out(c16), .overflow(ov16), .busy(busy16)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       ov;
  } vec8_t;

  vec8_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned carry and signed overflow from plain integer arithmetic.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
    int          sa, sb, r;
    logic [16:0] u;
    logic [15:0] res;
    logic        c, ov;
    sa = $signed(a);
    sb = $signed(b);
    if (s) begin
      res = a - b;
      c   = (a >= b);
      r   = sa - sb;
    end else begin
      u   = {1'b0, a} + {1'b0, b};
      res = u[15:0];
      c   = u[16];
      r   = sa + sb;
    end
    ov = (r > 32767) || (r < -32768);
    return {res, c, ov};
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input int stall_at, input int stall_len, output int lat);
    chk("in_ready_before_accept", in_ready8, 1);
    a8 = a; b8 = b; sub8 = s; in_valid8 = 1'b1;
    step;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~s;
    lat = 0;
    while (!out_valid8 && lat < 60) begin
      if (lat == stall_at) begin
        ena = 1'b0;
        repeat (stall_len) begin
          step;
          lat++;
          chk("stall_hold_busy", {out_valid8, busy8}, 2'b01);
        end
        ena = 1'b1;
      end
      step;
      lat++;
    end
  endtask

  task automatic release8;
    out_ready8 = 1'b1;
    step;
    out_ready8 = 1'b0;
    chk("release_idle", {out_valid8, in_ready8, busy8}, 3'b010);
  endtask

  initial begin
    int          lat;
    logic [15:0] ra, rb;
    logic        rs, acc, hs, done;
    logic [17:0] got, exp;
    logic [15:0] corners[4];

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    corners[0] = 16'h0000; corners[1] = 16'h7FFF; corners[2] = 16'h8000; corners[3] = 16'hFFFF;

    rst_n = 1'b0; ena = 1'b1;
    in_valid8 = 0; out_ready8 = 0; sub8 = 0; a8 = 0; b8 = 0;
    in_valid16 = 0; out_ready16 = 0; sub16 = 0; a16 = 0; b16 = 0;
    repeat (2) step;
    chk("reset8", {in_ready8, out_valid8, busy8, sum8, c8, ov8}, {3'b100, 8'h00, 2'b00});
    chk("reset16", {in_ready16, out_valid16, busy16, sum16, c16, ov16}, {3'b100, 16'h0000, 2'b00});
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].sub, -1, 0, lat);
      chk("vec_latency", lat, 8);
      chk("vec_result", {sum8, c8, ov8}, {vecs[i].s, vecs[i].c, vecs[i].ov});
      release8;
    end

    // Backpressure: result held while out_ready low; operands offered in DONE are not taken.
    run8(8'h0F, 8'h01, 1'b0, -1, 0, lat);
    in_valid8 = 1'b1; a8 = 8'h55; b8 = 8'h22;
    repeat (5) begin
      step;
      chk("bp_hold", {out_valid8, in_ready8, sum8, c8, ov8}, {2'b10, 8'h10, 2'b00});
    end
    in_valid8 = 1'b0;
    release8;
    step;
    chk("bp_not_queued", {busy8, in_ready8}, 2'b01);

    run8(8'h7F, 8'h01, 1'b0, 2, 3, lat);
    chk("stall_latency", lat, 11);
    chk("stall_result", {sum8, c8, ov8}, {8'h80, 2'b01});
    release8;

    // Reset during RUN digit 3 discards the operation.
    a8 = 8'hFF; b8 = 8'h01; sub8 = 0; in_valid8 = 1'b1;
    step;
    in_valid8 = 1'b0;
    repeat (3) step;
    chk("pre_reset_busy", busy8, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_vals", {in_ready8, out_valid8, busy8, sum8, c8, ov8}, {3'b100, 8'h00, 2'b00});
    repeat (2) begin
      step;
      chk("reset_no_valid", out_valid8, 0);
    end
    rst_n = 1'b1;
    repeat (8) begin
      step;
      chk("post_reset_no_valid", {out_valid8, busy8}, 2'b00);
    end
    run8(8'h12, 8'h34, 1'b0, -1, 0, lat);
    chk("post_reset_latency", lat, 8);
    chk("post_reset_result", {sum8, c8, ov8}, {8'h46, 2'b00});
    release8;

    // 16-bit, 4 bits per cycle.
    a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 0; in_valid16 = 1'b1;
    step;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 40) begin
      step;
      lat++;
    end
    chk("w16_latency", lat, 4);
    chk("w16_result", {sum16, c16, ov16}, {16'h0000, 2'b10});
    out_ready16 = 1'b1;
    step;
    out_ready16 = 1'b0;

    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 5) == 0) ra = corners[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) rb = corners[$urandom_range(0, 3)];
      exp = model16(ra, rb, rs);
      repeat ($urandom_range(0, 2)) step;
      a16 = ra; b16 = rb; sub16 = rs; in_valid16 = 1'b1;
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
        ena = ($urandom_range(0, 3) != 0);
        acc = in_valid16 && in_ready16 && ena;
        step;
        done = acc;
      end
      if (!done) chk("rand_accept_timeout", 0, 1);
      in_valid16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
      done = 1'b0;
      got = '0;
      for (int t = 0; t < 200 && !done; t++) begin
        ena = ($urandom_range(0, 3) != 0);
        out_ready16 = 1'($urandom);
        hs = out_valid16 && out_ready16 && ena;
        if (hs) got = {sum16, c16, ov16};
        step;
        done = hs;
      end
      out_ready16 = 1'b0;
      if (!done) chk("rand_result_timeout", 0, 1);
      else chk("rand_result", got, exp);
    end
    ena = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
